// File: rtl/missile_pkg.sv
// Shared types and constants for the missile fire-request path and the
// missile movement stage.
package missile_pkg;

  localparam int AMMO_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    FLIGHT   = 2'd2,
    COOLDOWN = 2'd3
  } fire_state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } direction_e;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Shoot-key conditioning: 2-flop synchronizer, level debouncer and a
// one-cycle rising-edge strobe on the debounced level.
module key_debouncer
  import missile_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic resetN,
  input  logic keyRaw,
  output logic debounced,
  output logic keyEdge
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic sync1_r;
  logic sync2_r;
  logic deb_r;
  logic deb_d_r;
  logic [CW-1:0] cnt_r;

  // Synchronizer and previous-level register for edge detection.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_d_r <= 1'b0;
    end else begin
      sync1_r <= keyRaw;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
    end
  end

  // A differing level must persist for DEBOUNCE_CYCLES cycles to be accepted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_r <= CW'(0);
      deb_r <= 1'b0;
    end else if (sync2_r == deb_r) begin
      cnt_r <= CW'(0);
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= CW'(0);
      deb_r <= ~deb_r;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign debounced = deb_r;
  assign keyEdge   = deb_r & ~deb_d_r;

endmodule

// File: rtl/missile_fire_ctrl.sv
// Fire-request front end: turns a debounced key edge into a single firePulse,
// gated by one-missile-in-flight, cooldown and a reloading ammo budget.
module missile_fire_ctrl
  import missile_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 1000,
  parameter int COOLDOWN_FRAMES    = 15,
  parameter int AMMO_MAX           = 5,
  parameter int RELOAD_FRAMES      = 60,
  parameter int ARM_TIMEOUT_FRAMES = 2
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              keyRaw,
  input  logic              fireEnable,
  input  logic              missileDrawEn,
  input  logic              collision,
  output logic              firePulse,
  output logic [AMMO_W-1:0] ammoCount,
  output logic              ready
);

  localparam int RW = cnt_width(RELOAD_FRAMES);
  localparam int CW = cnt_width(COOLDOWN_FRAMES);
  localparam int AW = cnt_width(ARM_TIMEOUT_FRAMES);
  localparam logic [AMMO_W-1:0] AMMO_FULL   = AMMO_W'(AMMO_MAX);
  localparam logic [RW-1:0]     RELOAD_LAST = RW'(RELOAD_FRAMES - 1);
  localparam logic [AW-1:0]     ARM_LAST    = AW'(ARM_TIMEOUT_FRAMES - 1);
  localparam logic [CW-1:0]     CD_LOAD     = CW'(COOLDOWN_FRAMES);

  fire_state_e       state_r;
  fire_state_e       state_nxt_s;
  logic              fire_r;
  logic              ready_r;
  logic [AMMO_W-1:0] ammo_r;
  logic [AMMO_W-1:0] ammo_nxt_s;
  logic [RW-1:0]     reload_cnt_r;
  logic [CW-1:0]     cd_cnt_r;
  logic [AW-1:0]     arm_cnt_r;
  logic              armed_r;
  logic              key_edge_s;
  logic              debounced_s;
  logic              fire_req_s;
  logic              reload_tick_s;
  logic              fire_dec_s;
  logic              arm_timeout_s;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk      (clk),
    .resetN   (resetN),
    .keyRaw   (keyRaw),
    .debounced(debounced_s),
    .keyEdge  (key_edge_s)
  );

  // Qualifiers feeding the FSM and the ammo update.
  always_comb begin
    fire_req_s    = key_edge_s & debounced_s & fireEnable & (ammo_r != AMMO_W'(0));
    reload_tick_s = (ammo_r < AMMO_FULL) & startOfFrame & (reload_cnt_r == RELOAD_LAST);
    fire_dec_s    = (state_r == FIRE) & (ammo_r != AMMO_W'(0));
    arm_timeout_s = ~armed_r & ~missileDrawEn & startOfFrame & (arm_cnt_r == ARM_LAST);
    case ({reload_tick_s, fire_dec_s})
      2'b10:   ammo_nxt_s = ammo_r + AMMO_W'(1);
      2'b01:   ammo_nxt_s = ammo_r - AMMO_W'(1);
      default: ammo_nxt_s = ammo_r;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (fire_req_s) state_nxt_s = FIRE;
        else            state_nxt_s = IDLE;
      end
      FIRE:   state_nxt_s = FLIGHT;
      FLIGHT: begin
        if (collision || (armed_r && !missileDrawEn) || arm_timeout_s) state_nxt_s = COOLDOWN;
        else                                                            state_nxt_s = FLIGHT;
      end
      COOLDOWN: begin
        if (cd_cnt_r == CW'(0)) state_nxt_s = IDLE;
        else                    state_nxt_s = COOLDOWN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, registered outputs and ammo.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= IDLE;
      fire_r  <= 1'b0;
      ready_r <= 1'b0;
      ammo_r  <= AMMO_FULL;
    end else begin
      state_r <= state_nxt_s;
      fire_r  <= (state_nxt_s == FIRE);
      ready_r <= (state_nxt_s == IDLE) & (ammo_nxt_s != AMMO_W'(0)) & fireEnable;
      ammo_r  <= ammo_nxt_s;
    end
  end

  // Reload frame counter runs only while ammo is below capacity.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      reload_cnt_r <= RW'(0);
    end else if (ammo_r >= AMMO_FULL) begin
      reload_cnt_r <= RW'(0);
    end else if (startOfFrame) begin
      reload_cnt_r <= (reload_cnt_r == RELOAD_LAST) ? RW'(0) : reload_cnt_r + RW'(1);
    end else begin
      reload_cnt_r <= reload_cnt_r;
    end
  end

  // Flight arming / lost-request timeout and cooldown frame counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      armed_r   <= 1'b0;
      arm_cnt_r <= AW'(0);
      cd_cnt_r  <= CW'(0);
    end else begin
      if (state_r == FIRE) begin
        armed_r   <= 1'b0;
        arm_cnt_r <= AW'(0);
      end else if (state_r == FLIGHT) begin
        if (missileDrawEn)                armed_r   <= 1'b1;
        else if (!armed_r && startOfFrame) arm_cnt_r <= arm_cnt_r + AW'(1);
      end
      if (state_r != COOLDOWN && state_nxt_s == COOLDOWN)
        cd_cnt_r <= CD_LOAD;
      else if (state_r == COOLDOWN && startOfFrame && cd_cnt_r != CW'(0))
        cd_cnt_r <= cd_cnt_r - CW'(1);
    end
  end

  assign firePulse = fire_r;
  assign ammoCount = ammo_r;
  assign ready     = ready_r;

endmodule

// File: doc/missile_fire_ctrl.md
Name: missile_fire_ctrl

Overview:
Fire-request front end for one tank's missile. It conditions the raw shoot key with a synchronizer, a debouncer and a rising-edge detector, and enforces one missile in flight, a per-shot cooldown and a reloading ammo budget. Its single-cycle firePulse drives inputKeyPressed of the missile movement stage. That stage's drawEn and the missile collision signal come back as flight-status feedback.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive clk cycles a changed synchronized key level must hold before the debounced level follows
COOLDOWN_FRAMES, 15, startOfFrame pulses to wait after a missile ends before the next shot is allowed
AMMO_MAX, 5, ammo capacity and reset value (1..15)
RELOAD_FRAMES, 60, startOfFrame pulses per +1 ammo while below AMMO_MAX
ARM_TIMEOUT_FRAMES, 2, frames to wait in FLIGHT for missileDrawEn to rise before giving up

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
keyRaw  in  1  raw shoot key, asynchronous to clk
fireEnable  in  1  game-running qualifier; 0 blocks new shots
missileDrawEn  in  1  drawEn from the missile movement stage
collision  in  1  missile collision pulse
firePulse  out  1  one-cycle shot request to the movement stage
ammoCount  out  4  current ammo
ready  out  1  high only in IDLE with ammoCount>0 and fireEnable=1

Behaviour:
- Reset (asynchronous, active-low resetN; clock clk): state=IDLE, firePulse=0, ammoCount=AMMO_MAX, synchronizer/debounced/edge registers=0, all counters=0.
- Input path: 2-flop synchronizer, then debounce counter. The counter clears whenever the synchronized level equals the debounced level. It otherwise increments, and when it reaches DEBOUNCE_CYCLES the debounced level flips and the counter clears.
- keyEdge = debounced rising edge, one cycle wide. Falling edges are ignored.
- Fixed latency: a clean keyRaw rise held from IDLE gives firePulse high DEBOUNCE_CYCLES+3 cycles after the rise.
- FSM states: IDLE, FIRE, FLIGHT, COOLDOWN.
  - IDLE: on keyEdge with ammoCount>0 and fireEnable=1, go to FIRE. Otherwise the edge is dropped; no queuing.
  - FIRE: firePulse=1 for exactly this cycle, ammoCount decrements, then unconditionally go to FLIGHT.
  - FLIGHT: an internal armed bit clears on entry and sets when missileDrawEn=1.
    - collision=1 → COOLDOWN.
    - armed=1 and missileDrawEn=0 → COOLDOWN.
    - armed still 0 after ARM_TIMEOUT_FRAMES startOfFrame pulses → COOLDOWN (lost-request guard).
  - COOLDOWN: load counter with COOLDOWN_FRAMES on entry; decrement on each startOfFrame; at 0 go to IDLE. COOLDOWN_FRAMES=0 returns to IDLE on the next cycle.
- keyEdge outside IDLE is discarded.
- fireEnable=0 only gates the IDLE→FIRE transition; a missile already in flight completes normally.
- Reload: a frame counter runs only while ammoCount<AMMO_MAX. It increments on startOfFrame and, on reaching RELOAD_FRAMES, clears and adds 1 to ammo. It is held at 0 while ammo is full.
- Reload and the FIRE decrement in the same cycle leave ammoCount unchanged. ammoCount never exceeds AMMO_MAX or underflows.
- firePulse is registered and never high for two consecutive cycles.
- Reset mid-flight returns to IDLE with full ammo immediately. No pulse is emitted.

Decomposition:
- missile_pkg: FSM state enum (IDLE/FIRE/FLIGHT/COOLDOWN), 2-bit direction typedef shared with the movement stage, ammo width constant (4).
- Sub-module key_debouncer: synchronizer, debounce counter and edge detector. Parameter DEBOUNCE_CYCLES; outputs debounced level and keyEdge.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, COOLDOWN_FRAMES=3, AMMO_MAX=2, RELOAD_FRAMES=5, ARM_TIMEOUT_FRAMES=2, startOfFrame every 20 cycles.)
- Clean press: keyRaw rises at cycle 10 and holds → firePulse high only at cycle 17; ammoCount 2→1; state FLIGHT.
- Bounce: keyRaw toggles every 2 cycles for 20 cycles, then settles low → no firePulse; debounced level stays 0.
- Flight and cooldown: after the shot, missileDrawEn=1 for 50 cycles then 0 → COOLDOWN; a press during COOLDOWN is dropped; IDLE after the 3rd startOfFrame; the next press fires.
- Ammo and reload: two shots empty ammo (ammoCount=0, ready=0); a press is dropped; after 5 frames ammoCount=1; reload coinciding with FIRE keeps ammoCount unchanged.
- Lost request: missileDrawEn held 0 after firePulse → COOLDOWN after 2 startOfFrame pulses; collision in FLIGHT → COOLDOWN next cycle.
- Reset/gate: resetN low during FLIGHT → IDLE, ammoCount=2, firePulse=0; fireEnable=0 with a press → no firePulse.
